// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard sequencer.
package pipe_ctrl_pkg;

  localparam int unsigned REG_W_DEF = 4;
  localparam int unsigned FWD_W     = 2;
  localparam int unsigned CNT_W     = 8;
  localparam int unsigned BCNT_W    = 2;

  typedef enum logic [1:0] {
    ST_RUN        = 2'd0,
    ST_LOAD_STALL = 2'd1,
    ST_BR_FLUSH   = 2'd2,
    ST_MEM_WAIT   = 2'd3
  } state_t;

  localparam logic [FWD_W-1:0] FWD_RF  = 2'b00;
  localparam logic [FWD_W-1:0] FWD_MEM = 2'b01;
  localparam logic [FWD_W-1:0] FWD_WB  = 2'b10;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Observation/control bundle between the pipeline registers and the hazard sequencer.
// Perf counter signals exist only when PIPE_PERF_CNT_EN is defined.
interface pipe_hazard_ctrl_if #(
  parameter int unsigned REG_W = pipe_ctrl_pkg::REG_W_DEF
);
  logic [REG_W-1:0] rs1_id, rs2_id, Rg_exe, Rg_mem, Rg_wb;
  logic             use1_id, use2_id;
  logic             we_reg_exe, load_exe, prohib_exe;
  logic             we_reg_mem, prohib_mem, we_reg_wb;
  logic             branch_taken_exe, mem_req_mem, mem_ready;

  logic             en_pc, en_if_id, en_id_exe, en_exe_mem;
  logic             flush_if_id, flush_id_exe, pc_redirect;
  logic [1:0]       fwd_a, fwd_b;
  logic             mem_err;
  logic [1:0]       state_o;
`ifdef PIPE_PERF_CNT_EN
  logic [31:0]      stall_cycles, flush_cycles;
`endif

  // Pipeline side: supplies stage fields, consumes controls.
  modport master (
    output rs1_id, rs2_id, use1_id, use2_id, Rg_exe, we_reg_exe, load_exe, prohib_exe,
           Rg_mem, we_reg_mem, prohib_mem, Rg_wb, we_reg_wb, branch_taken_exe,
           mem_req_mem, mem_ready,
    input  en_pc, en_if_id, en_id_exe, en_exe_mem, flush_if_id, flush_id_exe,
           pc_redirect, fwd_a, fwd_b, mem_err, state_o
`ifdef PIPE_PERF_CNT_EN
    , input stall_cycles, flush_cycles
`endif
  );

  // Sequencer side.
  modport slave (
    input  rs1_id, rs2_id, use1_id, use2_id, Rg_exe, we_reg_exe, load_exe, prohib_exe,
           Rg_mem, we_reg_mem, prohib_mem, Rg_wb, we_reg_wb, branch_taken_exe,
           mem_req_mem, mem_ready,
    output en_pc, en_if_id, en_id_exe, en_exe_mem, flush_if_id, flush_id_exe,
           pc_redirect, fwd_a, fwd_b, mem_err, state_o
`ifdef PIPE_PERF_CNT_EN
    , output stall_cycles, flush_cycles
`endif
  );

endinterface

// File: rtl/pipe_fwd_unit.sv
// Operand forwarding select for one source register; MEM result beats WB data.
module pipe_fwd_unit #(
  parameter int unsigned REG_W = pipe_ctrl_pkg::REG_W_DEF
) (
  input  logic [REG_W-1:0] rs,
  input  logic [REG_W-1:0] Rg_mem,
  input  logic             we_reg_mem,
  input  logic             prohib_mem,
  input  logic [REG_W-1:0] Rg_wb,
  input  logic             we_reg_wb,
  output logic [1:0]       fwd
);

  always_comb begin
    fwd = pipe_ctrl_pkg::FWD_RF;
    if (we_reg_mem && !prohib_mem && (Rg_mem == rs)) begin
      fwd = pipe_ctrl_pkg::FWD_MEM;
    end else if (we_reg_wb && (Rg_wb == rs)) begin
      fwd = pipe_ctrl_pkg::FWD_WB;
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencer: stalls, flushes and forwarding for the 5-stage filter core.
// Define PIPE_PERF_CNT_EN to add saturating stall/flush cycle counters.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned REG_W      = REG_W_DEF,
  parameter int unsigned BR_PENALTY = 1,
  parameter int unsigned MEM_TO     = 15
) (
  input  logic               clk,
  input  logic               rst_n,
  pipe_hazard_ctrl_if.slave  bus
);

  state_t              state, state_n, ret_state, ret_n;
  logic [CNT_W-1:0]    cnt, cnt_n;
  logic [BCNT_W-1:0]   br_cnt, br_cnt_n;
  logic                mem_err, err_n;

  logic mem_hold, lu, br, mem_done;
  logic pc_en, if_id_en, id_exe_en, exe_mem_en;
  logic if_flush, id_flush, redirect;
  logic [1:0] fwd_a_raw, fwd_b_raw;

  assign mem_hold = bus.mem_req_mem & ~bus.prohib_mem & ~bus.mem_ready;
  assign lu = bus.load_exe & bus.we_reg_exe & ~bus.prohib_exe &
              ((bus.use1_id & (bus.rs1_id == bus.Rg_exe)) |
               (bus.use2_id & (bus.rs2_id == bus.Rg_exe)));
  assign br = bus.branch_taken_exe & ~bus.prohib_exe;
  assign mem_done = bus.mem_ready | (cnt == CNT_W'(MEM_TO - 1));

  // Next-state and same-cycle control decode.
  always_comb begin
    pc_en      = 1'b1;
    if_id_en   = 1'b1;
    id_exe_en  = 1'b1;
    exe_mem_en = 1'b1;
    if_flush   = 1'b0;
    id_flush   = 1'b0;
    redirect   = 1'b0;
    state_n    = state;
    ret_n      = ret_state;
    cnt_n      = cnt;
    br_cnt_n   = br_cnt;
    err_n      = mem_err;

    if (state == ST_MEM_WAIT) begin
      if (mem_done) begin
        // Release cycle behaves like the interrupted state; a frozen branch flush still kills IF/ID.
        state_n  = ret_state;
        cnt_n    = '0;
        if_flush = (ret_state == ST_BR_FLUSH);
        if (!bus.mem_ready) err_n = 1'b1;
      end else begin
        pc_en      = 1'b0;
        if_id_en   = 1'b0;
        id_exe_en  = 1'b0;
        exe_mem_en = 1'b0;
        cnt_n      = cnt + CNT_W'(1);
      end
    end else if (mem_hold) begin
      pc_en      = 1'b0;
      if_id_en   = 1'b0;
      id_exe_en  = 1'b0;
      exe_mem_en = 1'b0;
      state_n    = ST_MEM_WAIT;
      ret_n      = state;
      cnt_n      = '0;
    end else begin
      case (state)
        ST_RUN: begin
          if (br) begin
            redirect = 1'b1;
            if_flush = 1'b1;
            id_flush = 1'b1;
            br_cnt_n = BCNT_W'(BR_PENALTY);
            state_n  = (BR_PENALTY == 0) ? ST_RUN : ST_BR_FLUSH;
          end else if (lu) begin
            pc_en    = 1'b0;
            if_id_en = 1'b0;
            id_flush = 1'b1;
            state_n  = ST_LOAD_STALL;
          end
        end
        ST_BR_FLUSH: begin
          if_flush = 1'b1;
          if (br_cnt <= BCNT_W'(1)) begin
            state_n = ST_RUN;
          end else begin
            br_cnt_n = br_cnt - BCNT_W'(1);
          end
        end
        default: state_n = ST_RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_RUN;
      ret_state <= ST_RUN;
      cnt       <= '0;
      br_cnt    <= '0;
      mem_err   <= 1'b0;
    end else begin
      state     <= state_n;
      ret_state <= ret_n;
      cnt       <= cnt_n;
      br_cnt    <= br_cnt_n;
      mem_err   <= err_n;
    end
  end

  pipe_fwd_unit #(.REG_W(REG_W)) u_fwd_a (
    .rs(bus.rs1_id), .Rg_mem(bus.Rg_mem), .we_reg_mem(bus.we_reg_mem),
    .prohib_mem(bus.prohib_mem), .Rg_wb(bus.Rg_wb), .we_reg_wb(bus.we_reg_wb),
    .fwd(fwd_a_raw)
  );

  pipe_fwd_unit #(.REG_W(REG_W)) u_fwd_b (
    .rs(bus.rs2_id), .Rg_mem(bus.Rg_mem), .we_reg_mem(bus.we_reg_mem),
    .prohib_mem(bus.prohib_mem), .Rg_wb(bus.Rg_wb), .we_reg_wb(bus.we_reg_wb),
    .fwd(fwd_b_raw)
  );

  // Reset forces a safe, all-bubble control pattern.
  assign bus.en_pc        = rst_n & pc_en;
  assign bus.en_if_id     = rst_n & if_id_en;
  assign bus.en_id_exe    = rst_n & id_exe_en;
  assign bus.en_exe_mem   = rst_n & exe_mem_en;
  assign bus.flush_if_id  = ~rst_n | if_flush;
  assign bus.flush_id_exe = ~rst_n | id_flush;
  assign bus.pc_redirect  = rst_n & redirect;
  assign bus.fwd_a        = rst_n ? fwd_a_raw : FWD_RF;
  assign bus.fwd_b        = rst_n ? fwd_b_raw : FWD_RF;
  assign bus.mem_err      = mem_err;
  assign bus.state_o      = state;

`ifdef PIPE_PERF_CNT_EN
  logic [31:0] stall_q, flush_q;
  logic        stall_now;

  assign stall_now = ~(pc_en & if_id_en & id_exe_en & exe_mem_en);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (stall_now && (stall_q != '1)) stall_q <= stall_q + 32'd1;
      if (if_flush && (flush_q != '1)) flush_q <= flush_q + 32'd1;
    end
  end

  assign bus.stall_cycles = stall_q;
  assign bus.flush_cycles = flush_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl with a queue scoreboard of per-cycle control vectors.
module tb_pipe_hazard_ctrl;

  localparam logic [1:0] S_RUN = 2'd0, S_LS = 2'd1, S_BF = 2'd2, S_MW = 2'd3;

  typedef struct {
    string       tag;
    logic [13:0] v;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  exp_t sb[$];
  int   total = 0;
  int   passed = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl_if #(.REG_W(4)) bus ();

  pipe_hazard_ctrl #(.REG_W(4), .BR_PENALTY(1), .MEM_TO(4)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave)
  );

  function automatic logic [13:0] ev(logic [3:0] en, logic [1:0] fl, logic rd,
                                     logic [1:0] fa, logic [1:0] fb, logic err,
                                     logic [1:0] st);
    return {en, fl, rd, fa, fb, err, st};
  endfunction

  function automatic logic [13:0] observed();
    return {bus.en_pc, bus.en_if_id, bus.en_id_exe, bus.en_exe_mem,
            bus.flush_if_id, bus.flush_id_exe, bus.pc_redirect,
            bus.fwd_a, bus.fwd_b, bus.mem_err, bus.state_o};
  endfunction

  task automatic idle();
    bus.rs1_id = 4'd0; bus.rs2_id = 4'd0; bus.use1_id = 1'b0; bus.use2_id = 1'b0;
    bus.Rg_exe = 4'd9; bus.we_reg_exe = 1'b0; bus.load_exe = 1'b0; bus.prohib_exe = 1'b0;
    bus.Rg_mem = 4'd10; bus.we_reg_mem = 1'b0; bus.prohib_mem = 1'b0;
    bus.Rg_wb = 4'd11; bus.we_reg_wb = 1'b0;
    bus.branch_taken_exe = 1'b0; bus.mem_req_mem = 1'b0; bus.mem_ready = 1'b0;
  endtask

  task automatic load_use();
    bus.load_exe = 1'b1; bus.we_reg_exe = 1'b1; bus.Rg_exe = 4'd5;
    bus.rs1_id = 4'd5; bus.use1_id = 1'b1;
  endtask

  // Push the expectation, compare mid-cycle, then advance to just after the next edge.
  task automatic cyc(string tag, logic [13:0] e);
    exp_t x;
    logic [13:0] o;
    sb.push_back('{tag: tag, v: e});
    @(negedge clk);
    x = sb.pop_front();
    o = observed();
    total++;
    assert (o === x.v) passed++;
    else $error("FAIL %s observed=%b expected=%b", x.tag, o, x.v);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    @(posedge clk);
    #1;
    cyc("reset", ev(4'b0000, 2'b11, 1'b0, 2'b00, 2'b00, 1'b0, S_RUN));

    rst_n = 1'b1;
    cyc("run_idle", ev(4'b1111, 2'b00, 1'b0, 2'b00, 2'b00, 1'b0, S_RUN));

    bus.rs1_id = 4'd3; bus.rs2_id = 4'd7;
    bus.we_reg_mem = 1'b1; bus.Rg_mem = 4'd3; bus.we_reg_wb = 1'b1; bus.Rg_wb = 4'd7;
    cyc("fwd_mem_wb", ev(4'b1111, 2'b00, 1'b0, 2'b01, 2'b10, 1'b0, S_RUN));
    bus.rs1_id = 4'd4; bus.rs2_id = 4'd4; bus.Rg_mem = 4'd4; bus.Rg_wb = 4'd4;
    cyc("fwd_mem_prio", ev(4'b1111, 2'b00, 1'b0, 2'b01, 2'b01, 1'b0, S_RUN));
    bus.prohib_mem = 1'b1;
    cyc("fwd_prohib", ev(4'b1111, 2'b00, 1'b0, 2'b10, 2'b10, 1'b0, S_RUN));

    idle(); load_use(); bus.use1_id = 1'b0; bus.rs2_id = 4'd5;
    cyc("lu_unused", ev(4'b1111, 2'b00, 1'b0, 2'b00, 2'b00, 1'b0, S_RUN));

    idle(); load_use();
    cyc("lu_stall", ev(4'b0011, 2'b01, 1'b0, 2'b00, 2'b00, 1'b0, S_RUN));
    bus.prohib_exe = 1'b1; bus.we_reg_mem = 1'b1; bus.Rg_mem = 4'd5;
    cyc("lu_fwd", ev(4'b1111, 2'b00, 1'b0, 2'b01, 2'b00, 1'b0, S_LS));
    idle();
    cyc("lu_done", ev(4'b1111, 2'b00, 1'b0, 2'b00, 2'b00, 1'b0, S_RUN));

    bus.branch_taken_exe = 1'b1;
    cyc("br_redirect", ev(4'b1111, 2'b11, 1'b1, 2'b00, 2'b00, 1'b0, S_RUN));
    idle(); bus.prohib_exe = 1'b1;
    cyc("br_flush", ev(4'b1111, 2'b10, 1'b0, 2'b00, 2'b00, 1'b0, S_BF));
    idle();
    cyc("br_done", ev(4'b1111, 2'b00, 1'b0, 2'b00, 2'b00, 1'b0, S_RUN));

    load_use(); bus.branch_taken_exe = 1'b1;
    cyc("br_lu_prio", ev(4'b1111, 2'b11, 1'b1, 2'b00, 2'b00, 1'b0, S_RUN));
    cyc("brflush_ignore", ev(4'b1111, 2'b10, 1'b0, 2'b00, 2'b00, 1'b0, S_BF));
    idle();
    cyc("br2_done", ev(4'b1111, 2'b00, 1'b0, 2'b00, 2'b00, 1'b0, S_RUN));

    bus.mem_req_mem = 1'b1; bus.prohib_mem = 1'b1;
    cyc("mw_prohib", ev(4'b1111, 2'b00, 1'b0, 2'b00, 2'b00, 1'b0, S_RUN));
    bus.prohib_mem = 1'b0;
    cyc("mw_hold0", ev(4'b0000, 2'b00, 1'b0, 2'b00, 2'b00, 1'b0, S_RUN));
    cyc("mw_hold1", ev(4'b0000, 2'b00, 1'b0, 2'b00, 2'b00, 1'b0, S_MW));
    cyc("mw_hold2", ev(4'b0000, 2'b00, 1'b0, 2'b00, 2'b00, 1'b0, S_MW));
    bus.mem_ready = 1'b1;
    cyc("mw_release", ev(4'b1111, 2'b00, 1'b0, 2'b00, 2'b00, 1'b0, S_MW));
    idle();
    cyc("mw_back", ev(4'b1111, 2'b00, 1'b0, 2'b00, 2'b00, 1'b0, S_RUN));

    bus.mem_req_mem = 1'b1;
    cyc("to_hold0", ev(4'b0000, 2'b00, 1'b0, 2'b00, 2'b00, 1'b0, S_RUN));
    for (int i = 0; i < 3; i++) begin
      cyc($sformatf("to_wait%0d", i), ev(4'b0000, 2'b00, 1'b0, 2'b00, 2'b00, 1'b0, S_MW));
    end
    cyc("to_release", ev(4'b1111, 2'b00, 1'b0, 2'b00, 2'b00, 1'b0, S_MW));
    idle();
    cyc("to_err_set", ev(4'b1111, 2'b00, 1'b0, 2'b00, 2'b00, 1'b1, S_RUN));
    cyc("to_err_sticky", ev(4'b1111, 2'b00, 1'b0, 2'b00, 2'b00, 1'b1, S_RUN));

    bus.branch_taken_exe = 1'b1;
    cyc("brmw_redirect", ev(4'b1111, 2'b11, 1'b1, 2'b00, 2'b00, 1'b1, S_RUN));
    idle(); bus.mem_req_mem = 1'b1;
    cyc("brmw_freeze", ev(4'b0000, 2'b00, 1'b0, 2'b00, 2'b00, 1'b1, S_BF));
    bus.mem_ready = 1'b1;
    cyc("brmw_release", ev(4'b1111, 2'b10, 1'b0, 2'b00, 2'b00, 1'b1, S_MW));
    idle();
    cyc("brmw_resume", ev(4'b1111, 2'b10, 1'b0, 2'b00, 2'b00, 1'b1, S_BF));
    cyc("brmw_done", ev(4'b1111, 2'b00, 1'b0, 2'b00, 2'b00, 1'b1, S_RUN));

    bus.mem_req_mem = 1'b1;
    cyc("rst_mw0", ev(4'b0000, 2'b00, 1'b0, 2'b00, 2'b00, 1'b1, S_RUN));
    cyc("rst_mw1", ev(4'b0000, 2'b00, 1'b0, 2'b00, 2'b00, 1'b1, S_MW));
    rst_n = 1'b0;
    bus.we_reg_mem = 1'b1; bus.Rg_mem = 4'd0; bus.we_reg_wb = 1'b1; bus.Rg_wb = 4'd0;
    bus.branch_taken_exe = 1'b1;
    cyc("rst_forced", ev(4'b0000, 2'b11, 1'b0, 2'b00, 2'b00, 1'b1, S_MW));
    rst_n = 1'b1;
    idle();
    cyc("rst_after", ev(4'b1111, 2'b00, 1'b0, 2'b00, 2'b00, 1'b0, S_RUN));
    bus.mem_req_mem = 1'b1;
    cyc("rst_cnt_clear0", ev(4'b0000, 2'b00, 1'b0, 2'b00, 2'b00, 1'b0, S_RUN));
    for (int i = 0; i < 3; i++) begin
      cyc($sformatf("rst_cnt_wait%0d", i), ev(4'b0000, 2'b00, 1'b0, 2'b00, 2'b00, 1'b0, S_MW));
    end
    cyc("rst_cnt_release", ev(4'b1111, 2'b00, 1'b0, 2'b00, 2'b00, 1'b0, S_MW));
    idle();
    cyc("final_run", ev(4'b1111, 2'b00, 1'b0, 2'b00, 2'b00, 1'b1, S_RUN));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Pipeline sequencer for the 5-stage filter processor.
- Drives the enable and bubble controls of the IF/ID, ID/EXE and EXE/MEM pipeline registers, and the PC enable.
- Detects load-use hazards, taken branches and multi-cycle data-memory accesses, and generates operand-forwarding selects.
- Sits beside the pipeline registers; observes register indices and control bits taken from them.

Parameters:
- REG_W, 4, register index width (16 registers, no hardwired zero).
- BR_PENALTY, 1, extra flush cycles after a branch redirect (covers synchronous IMEM latency); legal range 0..3.
- MEM_TO, 15, maximum MEM_WAIT cycles before timeout; legal range 1..255.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- rs1_id, rs2_id  in  REG_W  source indices of the instruction in ID
- use1_id, use2_id  in  1  source actually read
- Rg_exe  in  REG_W  destination of EXE
- we_reg_exe  in  1  EXE writes the register file
- load_exe  in  1  EXE is a memory load
- prohib_exe  in  1  EXE holds a bubble
- Rg_mem  in  REG_W  destination of MEM
- we_reg_mem  in  1  MEM writes the register file
- prohib_mem  in  1  MEM holds a bubble
- Rg_wb  in  REG_W  destination of WB
- we_reg_wb  in  1  WB writes the register file
- branch_taken_exe  in  1  EXE resolved a taken branch
- mem_req_mem  in  1  MEM stage accesses data memory (we_mem or load)
- mem_ready  in  1  data memory completes this cycle
- en_pc, en_if_id, en_id_exe, en_exe_mem  out  1 each  register load enables
- flush_if_id  out  1  load a bubble into IF/ID
- flush_id_exe  out  1  load prohib=1 into ID/EXE
- pc_redirect  out  1  PC loads the branch target
- fwd_a, fwd_b  out  2 each  00 = regfile, 01 = EXE/MEM result, 10 = WB data
- mem_err  out  1  sticky memory-timeout flag
- state_o  out  2  current FSM state

Behaviour:
- FSM states: RUN=0, LOAD_STALL=1, BR_FLUSH=2, MEM_WAIT=3. State and counters are registered; enables, flushes and forwarding selects are combinational from state and inputs, so control takes effect in the same cycle.
- Reset (rst_n=0 at a clk edge): state=RUN, cnt=0, mem_err=0. While rst_n=0, outputs are forced: all en_*=0, flush_*=1, pc_redirect=0, fwd_*=00.
- Hazard terms:
  - mem_hold = mem_req_mem & ~prohib_mem & ~mem_ready
  - lu = load_exe & we_reg_exe & ~prohib_exe & ((use1_id & rs1_id==Rg_exe) | (use2_id & rs2_id==Rg_exe))
  - br = branch_taken_exe & ~prohib_exe
- Priority in RUN: mem_hold > br > lu > normal.
- RUN, normal: all en_*=1, flush_*=0.
- mem_hold, in any state:
  - Freeze: all en_*=0, pc_redirect=0.
  - Next state MEM_WAIT, cnt=0. The state being frozen is saved in ret_state.
- MEM_WAIT:
  - Enables stay 0 and cnt increments each cycle.
  - mem_ready=1: that cycle all enables are restored per ret_state; next state is ret_state.
  - cnt==MEM_TO-1 without ready: mem_err<=1, forced release as if ready.
- br in RUN:
  - pc_redirect=1, flush_if_id=1, flush_id_exe=1, all en_*=1.
  - Next state BR_FLUSH with cnt=BR_PENALTY, or RUN if BR_PENALTY=0.
- BR_FLUSH:
  - flush_if_id=1, all en_*=1, cnt decrements.
  - Exit to RUN when cnt reaches 1.
  - br and lu are ignored, because ID/EXE holds bubbles.
- lu in RUN:
  - en_pc=0, en_if_id=0, en_id_exe=1 with flush_id_exe=1, en_exe_mem=1.
  - Next state LOAD_STALL, which lasts exactly 1 cycle of normal enables, then RUN. Forwarding from MEM resolves the operand.
- br and lu in the same cycle: br wins (the ID instruction is wrong-path).
- Forwarding, applied independently to each operand:
  - 01 if we_reg_mem & ~prohib_mem & Rg_mem==rs.
  - Otherwise 10 if we_reg_wb & Rg_wb==rs.
  - Otherwise 00.
  - MEM takes precedence over WB when both match.
- mem_err is cleared only by reset.

Optional Feature:
- Macro PIPE_PERF_CNT_EN.
- Defined:
  - Adds outputs stall_cycles[31:0] and flush_cycles[31:0].
  - stall_cycles increments each cycle any en_*=0 (mem_hold or lu). flush_cycles increments each cycle flush_if_id=1.
  - Both counters saturate at 0xFFFFFFFF and clear on reset.
- Undefined: the ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Package pipe_ctrl_pkg holds:
  - FSM state encoding.
  - FWD_RF=00, FWD_MEM=01, FWD_WB=10.
  - Default REG_W.
- Sub-module pipe_fwd_unit holds the purely combinational forwarding compare, instantiated once per operand. The FSM and counters stay in the top module.

Test Plan:
- Load-use: load_exe=1, Rg_exe=5, rs1_id=5, use1_id=1 → one cycle with en_pc=0, en_if_id=0, flush_id_exe=1; next cycle fwd_a=01 when Rg_mem=5.
- Branch, BR_PENALTY=1: branch_taken_exe=1 → pc_redirect=1 and both flushes that cycle; next cycle flush_if_id=1 only; then RUN.
- Memory wait: mem_req_mem=1, mem_ready=0 for 3 cycles → all en_*=0 for 3 cycles, released on the cycle mem_ready=1; mem_err stays 0.
- Timeout, MEM_TO=4: mem_ready held 0 → mem_err=1 after 4 MEM_WAIT cycles, return to RUN, mem_err stays 1.
- Priority: br and lu asserted together → branch flush only, no stall. mem_hold during BR_FLUSH → freeze, then resume BR_FLUSH with the remaining count.
- Reset mid-MEM_WAIT: rst_n=0 for 1 cycle → state=RUN, mem_err=0, cnt=0, outputs forced to reset values during reset.
